// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   INSTR_W           : instruction word width
//   PC_STEP           : byte distance between consecutive instruction words
//   LAST_ADDR_DEFAULT : byte address of the final populated instruction word
//   fetch_state_e     : fetch controller states
package cpu_pkg;

  localparam int INSTR_W           = 32;
  localparam int PC_STEP           = 4;
  localparam int LAST_ADDR_DEFAULT = 356;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf2.sv
// Two-entry synchronous FIFO with flush. The head entry always lives in
// slot 0, so the head outputs come straight from a register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : empties the FIFO; overrides push and pop
//   push_i       : write push_data_i at the tail (ignored when full without pop)
//   push_data_i  : entry to write
//   pop_i        : remove the head (ignored when empty)
//   head_o       : head entry contents
//   valid_o      : FIFO holds at least one entry
//   count_o      : number of entries held (0..2)
module fetch_buf2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] slot0_q, slot1_q;
  logic [1:0]   count_q;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  // NOTE: the storage slots are reset too, because slot 0 is a visible
  // output whose value must be defined (zero) straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      count_q <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b11: begin
          if (count_q == 2'd2) begin
            slot0_q <= slot1_q;
            slot1_q <= push_data_i;
          end else begin
            slot0_q <= push_data_i;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) slot0_q <= push_data_i;
          else                 slot1_q <= push_data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          slot0_q <= slot1_q;
          count_q <= count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_o  = slot0_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads a combinational instruction
// memory every cycle, buffers {pc, instr} pairs in a two-entry FIFO and
// hands them to decode over a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pulse that begins fetching from the current PC (IDLE only)
//   imem_addr         : byte address to instruction memory (equals the PC)
//   imem_rdata        : word returned for imem_addr in the same cycle
//   redirect_valid    : load redirect_pc and flush the buffer (highest priority)
//   redirect_pc       : redirect target byte address
//   if_valid/if_ready : decode handshake
//   if_instr, if_pc   : head instruction and its byte address
//   done              : fetching has finished and the buffer is empty
//   misalign_err      : sticky flag, a misaligned redirect target was seen
//   fetch_count       : instructions accepted by decode since reset (wraps)
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LAST_ADDR_DEFAULT),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              done,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  fetch_state_e        state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic                misalign_q;
  logic [CNT_W-1:0]    fcnt_q;

  logic [ENTRY_W-1:0]  head;
  logic [1:0]          buf_count;
  logic                space, push, pop, past_end;

  // Room for one more entry, counting the slot freed by a pop this cycle.
  assign space    = (buf_count != 2'd2) || (if_valid && if_ready);
  assign past_end = (pc_q > LAST_ADDR);
  // A redirect discards both the pending pop and any push this cycle.
  assign pop      = if_valid && if_ready && !redirect_valid;
  assign push     = (state_q == FS_RUN) && !redirect_valid && space && !past_end;

  fetch_buf2 #(
    .W (ENTRY_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({pc_q, imem_rdata}),
    .pop_i       (pop),
    .head_o      (head),
    .valid_o     (if_valid),
    .count_o     (buf_count)
  );

  // NOTE: every register here is sequential state, so it is written only
  // with non-blocking assignments; combinational helpers live in assigns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      if (pop) fcnt_q <= fcnt_q + CNT_W'(1);

      if (redirect_valid) begin
        state_q <= FS_RUN;
        pc_q    <= {redirect_pc[ADDR_W-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
      end else begin
        unique case (state_q)
          FS_IDLE: if (start) state_q <= FS_RUN;
          FS_RUN: begin
            if (past_end) begin
              // Landed beyond the program: stop without fetching.
              state_q <= FS_DONE;
            end else if (push) begin
              pc_q <= pc_q + ADDR_W'(PC_STEP);
              if (pc_q == LAST_ADDR) state_q <= FS_DONE;
            end
          end
          FS_DONE: ;
          default: state_q <= FS_IDLE;
        endcase
      end
    end
  end

  assign imem_addr    = pc_q;
  assign if_pc        = head[ENTRY_W-1 -: ADDR_W];
  assign if_instr     = head[DATA_W-1:0];
  // Derived only from registered state, so it cannot glitch on inputs.
  assign done         = (state_q == FS_DONE) && (buf_count == 2'd0);
  assign misalign_err = misalign_q;
  assign fetch_count  = fcnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        done;
  logic        misalign_err;
  logic [15:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .done           (done),
    .misalign_err   (misalign_err),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: 90 words at 0..356, a few fixed encodings.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a > 32'd356)  return 32'h0;
    if (a == 32'd0)   return 32'h8D100200;
    if (a == 32'd44)  return 32'hAD100100;
    if (a == 32'd120) return 32'h8D08020C;
    return 32'h1300_0000 | a;
  endfunction

  always_comb imem_rdata = word_at(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_addr;
    logic [15:0] exp_fc;
  } vec_t;

  vec_t vt[14];

  initial begin
    int n;
    logic seq_ok;
    logic [31:0] first_instr;
    logic found;

    // Back-pressure table: start, ten cycles stalled, then release.
    vt[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 32'd0,  16'd0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd4,  16'd0};
    for (int i = 2; i <= 10; i++) vt[i] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd8, 16'd0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 32'd4, 32'd12, 16'd1};
    vt[12] = '{1'b0, 1'b1, 1'b1, 32'd8, 32'd16, 16'd2};
    vt[13] = '{1'b0, 1'b0, 1'b1, 32'd8, 32'd16, 16'd2};

    // ---- reset state ----
    do_reset();
    check("rst_valid", 64'(if_valid), 64'd0);
    check("rst_instr", 64'(if_instr), 64'd0);
    check("rst_pc", 64'(if_pc), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_misalign", 64'(misalign_err), 64'd0);
    check("rst_fcount", 64'(fetch_count), 64'd0);
    step();
    check("idle_no_fetch", 64'(if_valid), 64'd0);

    // ---- back-pressure table ----
    for (int i = 0; i < 14; i++) begin
      start = vt[i].start;
      if_ready = vt[i].ready;
      step();
      check($sformatf("bp%0d_valid", i), 64'(if_valid), 64'(vt[i].exp_valid));
      check($sformatf("bp%0d_addr", i), 64'(imem_addr), 64'(vt[i].exp_addr));
      check($sformatf("bp%0d_fcount", i), 64'(fetch_count), 64'(vt[i].exp_fc));
      if (vt[i].exp_valid) begin
        check($sformatf("bp%0d_pc", i), 64'(if_pc), 64'(vt[i].exp_pc));
        check($sformatf("bp%0d_instr", i), 64'(if_instr), 64'(word_at(vt[i].exp_pc)));
      end
    end

    // ---- full program stream with decode always ready ----
    do_reset();
    if_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0; seq_ok = 1'b1; first_instr = '0;
    for (int c = 0; c < 400 && !(n >= 90 && !if_valid); c++) begin
      if (if_valid) begin
        if (n == 0) first_instr = if_instr;
        if (seq_ok && (if_pc !== 32'(n * 4) || if_instr !== word_at(32'(n * 4)))) begin
          seq_ok = 1'b0;
          $display("stream item %0d: pc=0x%0h instr=0x%0h", n, if_pc, if_instr);
        end
        n++;
      end
      step();
    end
    check("stream_order", 64'(seq_ok), 64'd1);
    check("stream_len", 64'(n), 64'd90);
    check("stream_first_instr", 64'(first_instr), 64'h8D100200);
    check("stream_done", 64'(done), 64'd1);
    check("stream_fcount", 64'(fetch_count), 64'd90);
    check("stream_pc_end", 64'(imem_addr), 64'd360);

    // ---- misaligned redirect out of DONE ----
    redirect_valid = 1'b1; redirect_pc = 32'h2E;
    step();
    redirect_valid = 1'b0;
    check("mis_flag", 64'(misalign_err), 64'd1);
    check("mis_done", 64'(done), 64'd0);
    check("mis_addr", 64'(imem_addr), 64'd44);
    step();
    check("mis_valid", 64'(if_valid), 64'd1);
    check("mis_pc", 64'(if_pc), 64'd44);
    check("mis_instr", 64'(if_instr), 64'hAD100100);

    // ---- redirect while head is pc=40 and decode ready ----
    do_reset();
    check("rst_clears_misalign", 64'(misalign_err), 64'd0);
    if_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (if_valid && if_pc == 32'd40) found = 1'b1;
      else step();
    end
    check("redir_head40_seen", 64'(found), 64'd1);
    check("redir_fcount_before", 64'(fetch_count), 64'd10);
    redirect_valid = 1'b1; redirect_pc = 32'd120;
    step();
    redirect_valid = 1'b0;
    check("redir_flush_valid", 64'(if_valid), 64'd0);
    check("redir_pop_dropped", 64'(fetch_count), 64'd10);
    check("redir_addr", 64'(imem_addr), 64'd120);
    step();
    check("redir_valid", 64'(if_valid), 64'd1);
    check("redir_pc", 64'(if_pc), 64'd120);
    check("redir_instr", 64'(if_instr), 64'h8D08020C);

    // ---- asynchronous reset with two entries buffered ----
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("ar_pre_addr", 64'(imem_addr), 64'd8);
    check("ar_pre_valid", 64'(if_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_valid_now", 64'(if_valid), 64'd0);
    check("ar_addr_now", 64'(imem_addr), 64'd0);
    check("ar_pc_now", 64'(if_pc), 64'd0);
    #1 rst_n = 1'b1;
    if_ready = 1'b1;
    step(); step(); step();
    check("ar_idle_valid", 64'(if_valid), 64'd0);
    check("ar_idle_addr", 64'(imem_addr), 64'd0);

    // ---- redirect and start together from IDLE ----
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd200;
    step();
    start = 1'b0; redirect_valid = 1'b0;
    check("rs_addr", 64'(imem_addr), 64'd200);
    check("rs_valid", 64'(if_valid), 64'd0);
    step();
    check("rs_head_valid", 64'(if_valid), 64'd1);
    check("rs_head_pc", 64'(if_pc), 64'd200);
    check("rs_head_instr", 64'(if_instr), 64'(word_at(32'd200)));
    check("rs_next_addr", 64'(imem_addr), 64'd204);

    // ---- redirect beyond the last word ----
    redirect_valid = 1'b1; redirect_pc = 32'd400;
    step();
    redirect_valid = 1'b0;
    check("oob_addr", 64'(imem_addr), 64'd400);
    check("oob_valid", 64'(if_valid), 64'd0);
    step();
    check("oob_done", 64'(done), 64'd1);
    check("oob_no_push", 64'(if_valid), 64'd0);
    check("oob_addr_hold", 64'(imem_addr), 64'd400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
